// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch front end handshake bundle
// Purpose: groups the redirect/halt controls, the instruction-memory port and
//          the decode-facing head-of-queue handshake of fetch_queue.
// Ports (signals):
//   redirect, redirect_pc     EX-stage flush and new fetch PC
//   halt                      stop issuing fetches
//   if_ready                  decode accepts the head entry
//   imem_req, imem_addr       instruction-memory read request
//   imem_rdata                read data, one cycle after imem_req
//   if_valid, if_pc, if_instr head entry of the queue
//   count                     queue occupancy
// Modports: master = fetch_queue side, slave = core/memory side.
interface fetch_queue_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic             halt;
  logic             if_ready;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_rdata;
  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic [INS_W-1:0] if_instr;
  logic [CW-1:0]    count;

  modport master (
    input  redirect, redirect_pc, halt, if_ready, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_instr, count
  );

  modport slave (
    output redirect, redirect_pc, halt, if_ready, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - RV32 instruction fetch PC, imem request and IF queue
// Purpose: owns the fetch PC, issues one word read per cycle to a synchronous
//          instruction memory while credits allow, buffers {pc, instr} pairs
//          in a DEPTH-entry FIFO drained by decode, and flushes on redirect.
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   io_bus  fetch_queue_if.master (redirect/halt, imem port, decode handshake)
module fetch_queue #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master io_bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PC_W-1:0]  r_fetch_pc;
  logic [PC_W-1:0]  r_pc_mem    [DEPTH];
  logic [INS_W-1:0] r_instr_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_inflight;
  logic [PC_W-1:0]  r_inflight_pc;

  logic [CW:0]      w_occ;
  logic             w_req;
  logic             w_push;
  logic             w_pop;

  // A request only issues when a slot is reserved for its response: the
  // buffered entries plus the one in flight must leave room. A pop in the
  // same cycle does not count as a credit, which keeps the path short.
  assign w_occ  = {1'b0, r_count} + (CW+1)'(r_inflight);
  assign w_req  = reset && !io_bus.halt && !io_bus.redirect &&
                  (w_occ < (CW+1)'(DEPTH));
  assign w_push = r_inflight && !io_bus.redirect;
  assign w_pop  = (r_count != '0) && io_bus.if_ready;

  assign io_bus.imem_req  = w_req;
  assign io_bus.imem_addr = r_fetch_pc;
  assign io_bus.if_valid  = (r_count != '0);
  assign io_bus.if_pc     = r_pc_mem[r_rd_ptr];
  assign io_bus.if_instr  = r_instr_mem[r_rd_ptr];
  assign io_bus.count     = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (io_bus.redirect) begin
      // Flush wins: the response landing this cycle and any coincident pop
      // leave no trace in the queue state.
      r_fetch_pc <= {io_bus.redirect_pc[PC_W-1:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + PC_W'(4);
      end
      if (w_push) begin
        r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
        r_instr_mem[r_wr_ptr] <= io_bus.imem_rdata;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_req  = 0;

  fetch_queue_if #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: word n holds n; junk when no request was made.
  always @(posedge clk)
    bus.imem_rdata <= bus.imem_req ? 32'(bus.imem_addr >> 2) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Asserts reset, releases it on a falling edge; returns 1 ns into C0.
  task automatic start(input logic rdy);
    reset           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.halt        = 1'b0;
    bus.if_ready    = rdy;
    #1;
    nxt();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.halt        = 1'b0;
    bus.if_ready    = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_count", 32'(bus.count),    32'd0);
    chk("rst_pc",    32'(bus.if_pc),    32'd0);
    chk("rst_instr", bus.if_instr,      32'd0);
    chk("rst_req",   32'(bus.imem_req), 32'd0);

    // Streaming with if_ready high.
    start(1'b1);
    chk("c0_req",  32'(bus.imem_req),  32'd1);
    chk("c0_addr", 32'(bus.imem_addr), 32'h000);
    nxt(); #1;
    chk("c1_addr",  32'(bus.imem_addr), 32'h004);
    chk("c1_valid", 32'(bus.if_valid),  32'd0);
    nxt(); #1;
    for (int k = 0; k < 6; k++) begin
      chk("str_valid", 32'(bus.if_valid), 32'd1);
      chk("str_pc",    32'(bus.if_pc),    32'(4 * k));
      chk("str_instr", bus.if_instr,      32'(k));
      chk("str_count", 32'(bus.count),    32'd1);
      nxt(); #1;
    end
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.if_valid), 32'd0);
    chk("arst_count", 32'(bus.count),    32'd0);

    // Backpressure: fill, stop issuing, drain in order, resume at 0x010.
    start(1'b0);
    n_req = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.imem_req) n_req++;
      if (c == 4) chk("bp_req_c4",   32'(bus.imem_req), 32'd0);
      if (c == 5) chk("bp_count_c5", 32'(bus.count),    32'd4);
      nxt(); #1;
    end
    chk("bp_nreq", 32'(n_req), 32'd4);
    bus.if_ready = 1'b1;
    #1;
    chk("bp_pc0",  32'(bus.if_pc),    32'h000);
    chk("bp_req0", 32'(bus.imem_req), 32'd0);
    nxt(); #1;
    chk("bp_pc1",   32'(bus.if_pc),     32'h004);
    chk("bp_cnt1",  32'(bus.count),     32'd3);
    chk("bp_req1",  32'(bus.imem_req),  32'd1);
    chk("bp_addr1", 32'(bus.imem_addr), 32'h010);
    nxt(); #1;
    chk("bp_pc2", 32'(bus.if_pc), 32'h008);
    nxt(); #1;
    chk("bp_pc3", 32'(bus.if_pc), 32'h00C);
    nxt(); #1;
    chk("bp_pc4",    32'(bus.if_pc), 32'h010);
    chk("bp_instr4", bus.if_instr,   32'd4);

    // Redirect with count=3 and a fetch in flight.
    start(1'b0);
    for (int c = 0; c < 4; c++) nxt();
    #1;
    chk("rd_count_pre", 32'(bus.count), 32'd3);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 9'h040;
    #1;
    chk("rd_req_r", 32'(bus.imem_req), 32'd0);
    nxt();
    bus.redirect = 1'b0;
    bus.if_ready = 1'b1;
    #1;
    chk("rd_valid_r1", 32'(bus.if_valid),  32'd0);
    chk("rd_count_r1", 32'(bus.count),     32'd0);
    chk("rd_req_r1",   32'(bus.imem_req),  32'd1);
    chk("rd_addr_r1",  32'(bus.imem_addr), 32'h040);
    nxt(); #1;
    chk("rd_valid_r2", 32'(bus.if_valid),  32'd0);
    chk("rd_addr_r2",  32'(bus.imem_addr), 32'h044);
    nxt(); #1;
    chk("rd_valid_r3", 32'(bus.if_valid), 32'd1);
    chk("rd_pc_r3",    32'(bus.if_pc),    32'h040);
    chk("rd_instr_r3", bus.if_instr,      32'h010);
    nxt(); #1;
    chk("rd_pc_r4", 32'(bus.if_pc), 32'h044);

    // Redirect coinciding with a pop at count=1.
    chk("rp_count_pre", 32'(bus.count), 32'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 9'h100;
    #1;
    nxt();
    bus.redirect = 1'b0;
    #1;
    chk("rp_count", 32'(bus.count),     32'd0);
    chk("rp_valid", 32'(bus.if_valid),  32'd0);
    chk("rp_addr",  32'(bus.imem_addr), 32'h100);
    nxt(); #1;
    chk("rp_valid2", 32'(bus.if_valid), 32'd0);
    nxt(); #1;
    chk("rp_valid3", 32'(bus.if_valid), 32'd1);
    chk("rp_pc3",    32'(bus.if_pc),    32'h100);
    chk("rp_instr3", bus.if_instr,      32'h040);

    // Halt with inflight=1, count=2.
    start(1'b0);
    for (int c = 0; c < 3; c++) nxt();
    #1;
    chk("h_count_pre", 32'(bus.count), 32'd2);
    bus.halt = 1'b1;
    #1;
    chk("h_req0", 32'(bus.imem_req), 32'd0);
    nxt(); #1;
    chk("h_count1", 32'(bus.count),    32'd3);
    chk("h_req1",   32'(bus.imem_req), 32'd0);
    nxt(); #1;
    chk("h_count2", 32'(bus.count),    32'd3);
    chk("h_req2",   32'(bus.imem_req), 32'd0);
    bus.halt = 1'b0;
    #1;
    chk("h_req3",  32'(bus.imem_req),  32'd1);
    chk("h_addr3", 32'(bus.imem_addr), 32'h00C);

    // PC wrap through a misaligned redirect target.
    start(1'b1);
    for (int c = 0; c < 3; c++) nxt();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 9'h1FB;
    #1;
    chk("w_req_r", 32'(bus.imem_req), 32'd0);
    nxt();
    bus.redirect = 1'b0;
    #1;
    chk("w_addr1", 32'(bus.imem_addr), 32'h1F8);
    nxt(); #1;
    chk("w_addr2", 32'(bus.imem_addr), 32'h1FC);
    nxt(); #1;
    chk("w_pc3",    32'(bus.if_pc),     32'h1F8);
    chk("w_instr3", bus.if_instr,       32'h07E);
    chk("w_addr3",  32'(bus.imem_addr), 32'h000);
    nxt(); #1;
    chk("w_pc4",    32'(bus.if_pc), 32'h1FC);
    chk("w_instr4", bus.if_instr,   32'h07F);
    nxt(); #1;
    chk("w_pc5",    32'(bus.if_pc), 32'h000);
    chk("w_instr5", bus.if_instr,   32'h000);
    nxt(); #1;
    chk("w_pc6", 32'(bus.if_pc), 32'h004);
    #2 reset = 1'b0;
    #1;
    chk("w_arst_valid", 32'(bus.if_valid), 32'd0);
    chk("w_arst_count", 32'(bus.count),    32'd0);
    chk("w_arst_req",   32'(bus.imem_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end feeding the IF/ID pipeline register of the 5-stage RV32 core. Owns the fetch PC, issues word reads to the synchronous instruction memory, and buffers returned instructions with their PCs in a small FIFO. Decode drains the FIFO through a valid/ready handshake. Branch/jump redirects from EX flush all buffered and in-flight fetches.

## Interface
- PC_W, 9: fetch PC / instruction-memory byte-address width
- INS_W, 32: instruction width
- DEPTH, 4: FIFO entries; power of two, at least 2
- clk  in  1: clock, rising edge
- reset  in  1: one clock; reset is asynchronous and active-low
- redirect  in  1: EX-stage branch taken / jump; flush and reload PC
- redirect_pc  in  PC_W: target PC, valid with redirect
- halt  in  1: stop issuing new fetches; the FIFO still drains
- if_ready  in  1: decode accepts the head entry this cycle (stall = 0)
- imem_req  out  1: read request to instruction memory
- imem_addr  out  PC_W: request address, equal to the fetch PC
- imem_rdata  in  INS_W: read data, valid exactly 1 cycle after imem_req
- if_valid  out  1: head entry present
- if_pc  out  PC_W: PC of the head entry
- if_instr  out  INS_W: instruction of the head entry
- count  out  $clog2(DEPTH)+1: current FIFO occupancy

## Operation
- State:
  - fetch_pc
  - FIFO of DEPTH {pc, instr} entries, with rd_ptr, wr_ptr and count
  - one in-flight flag `inflight` with its tag `inflight_pc`
- Issue:
  - imem_req = !halt && !redirect && (count + inflight) < DEPTH.
  - When a request issues: inflight <= 1, inflight_pc <= fetch_pc, and fetch_pc <= fetch_pc + 4, modulo 2^PC_W (wraps 0x1FC -> 0x000).
  - If no request issues, inflight <= 0.
- Response: when inflight = 1 and there is no redirect this cycle, write {inflight_pc, imem_rdata} at wr_ptr and increment wr_ptr.
- Pop: a transfer occurs when if_valid && if_ready, and rd_ptr then increments. if_ready with an empty FIFO is ignored.
- Count: count += push - pop. A simultaneous push and pop leaves count unchanged.
- Outputs: if_valid = (count != 0). if_pc and if_instr show the entry at rd_ptr. There is no bypass from imem_rdata.
- Redirect, which has priority over everything else:
  - Same edge: count, rd_ptr and wr_ptr go to 0, inflight goes to 0, and fetch_pc <= redirect_pc.
  - The response arriving in the redirect cycle is discarded.
  - No request issues in the redirect cycle.
  - A pop that coincides with a redirect is still considered consumed by decode. The flush wins for the FIFO state.
- Halt:
  - Issuing stops the cycle halt is high.
  - A request already in flight still completes and is pushed.
  - fetch_pc holds.
  - Deasserting halt resumes fetching at fetch_pc.
- Credit rule: the FIFO never overflows, because a request issues only when a free slot is reserved for it. A pop in the same cycle does not grant a credit.
- Misaligned redirect_pc: the low 2 bits are forced to 0.

## Timing
- Reset asserted, immediately and asynchronously:
  - fetch_pc = 0
  - count = 0, with both pointers at 0
  - inflight = 0
  - if_valid = 0, if_pc = 0, if_instr = 0 (FIFO storage cleared)
  - imem_req low while reset is low
- First cycle after reset release (C0): imem_req = 1, imem_addr = 0x000.
- C1: data for 0x000 arrives and is pushed. imem_addr = 0x004.
- C2: if_valid = 1 with if_pc = 0x000. Fetch-to-visible latency is 2 cycles.
- Steady state with if_ready held high: one instruction per cycle. count settles at 1 and inflight stays at 1.
- if_ready low: the FIFO fills to DEPTH and imem_req drops once count + inflight = DEPTH. The request reissues in the cycle after the first pop frees a credit.
- Redirect in cycle R:
  - R+1: imem_req = 1, imem_addr = redirect_pc, if_valid = 0.
  - R+2: the target instruction is pushed.
  - R+3: if_valid = 1 with if_pc = redirect_pc.
- Reset asserted mid-operation: all state clears asynchronously. Any pending memory response is ignored because inflight = 0.

## Test plan
- Reset release, if_ready=1, memory word n = n: required response is if_pc sequence 0x000, 0x004, 0x008… from C2, one per cycle, with if_instr matching.
- if_ready=0 for 10 cycles after C0: required response is count reaching 4, imem_req low from the cycle count + inflight = 4, and exactly 4 requests total. Raising if_ready then drains 0x000..0x00C in order, and fetching resumes at 0x010.
- Redirect to 0x040 while count=3 with a fetch in flight: required response is if_valid=0 the next cycle, no stale entries ever appearing, and the first popped pc being 0x040 at R+3.
- Redirect and if_ready in the same cycle with count=1: required response is count=0 after the edge and no duplicate pop.
- halt=1 with inflight=1, count=2: required response is the in-flight word pushed (count=3) and then no further imem_req. After halt=0, the next imem_addr equals the held fetch_pc.
- Fetch PC wrap: redirect to 0x1F8, if_ready=1; required response is the pc sequence 0x1F8, 0x1FC, 0x000, 0x004. Async reset pulsed mid-stream clears if_valid and count with no clock edge required.
